// File: rtl/err_mon_pkg.sv
// Shared types and sizing helpers for the approximate-circuit error monitor.
package err_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned PIPE_DEPTH = 2;

  localparam logic [1:0] ACC_CNT = 2'd0;
  localparam logic [1:0] ACC_HD  = 2'd1;
  localparam logic [1:0] ACC_ABS = 2'd2;

  // Accumulator widths large enough that a full 2**in_w run never wraps.
  function automatic int unsigned acc_width(input int unsigned in_w,
                                            input int unsigned out_w,
                                            input logic [1:0]  kind);
    case (kind)
      ACC_HD:  return in_w + $clog2(out_w + 1);
      ACC_ABS: return in_w + out_w;
      default: return in_w + 1;
    endcase
  endfunction

endpackage

// File: rtl/err_mon_diff.sv
// Per-pair error terms: XOR difference, its popcount and the absolute difference.
module err_mon_diff #(
  parameter int unsigned OUT_W = 4,
  parameter int unsigned POP_W = $clog2(OUT_W + 1)
) (
  input  logic [OUT_W-1:0] exact_po,
  input  logic [OUT_W-1:0] approx_po,
  output logic [OUT_W-1:0] diff_c,
  output logic [POP_W-1:0] pop_c,
  output logic [OUT_W-1:0] abs_c
);

  logic [OUT_W-1:0] w_diff;

  always_comb begin
    w_diff = exact_po ^ approx_po;
    diff_c = w_diff;
    pop_c  = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      pop_c = pop_c + POP_W'(w_diff[i]);
    end
    // Larger minus smaller keeps the unsigned result exact.
    if (exact_po >= approx_po) abs_c = exact_po - approx_po;
    else                       abs_c = approx_po - exact_po;
  end

endmodule

// File: rtl/approx_error_monitor.sv
// Streaming exact-vs-approximate output checker accumulating error metrics over 2**IN_W vectors.
// Optional macro ERR_MON_WORST_VEC_EN builds the worst-vector index capture.
module approx_error_monitor
  import err_mon_pkg::*;
#(
  parameter int unsigned IN_W  = 7,
  parameter int unsigned OUT_W = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [OUT_W-1:0]                  exact_po,
  input  logic [OUT_W-1:0]                  approx_po,
  output logic                              busy,
  output logic                              done,
  output logic [IN_W:0]                     vec_cnt,
  output logic [IN_W:0]                     mismatch_cnt,
  output logic [IN_W+$clog2(OUT_W+1)-1:0]   hd_sum,
  output logic [IN_W+OUT_W-1:0]             abs_err_sum,
  output logic [OUT_W-1:0]                  max_abs_err,
  output logic [IN_W-1:0]                   worst_vec
);

  localparam int unsigned CNT_W     = acc_width(IN_W, OUT_W, ACC_CNT);
  localparam int unsigned HD_W      = acc_width(IN_W, OUT_W, ACC_HD);
  localparam int unsigned ABS_W     = acc_width(IN_W, OUT_W, ACC_ABS);
  localparam int unsigned POP_W     = $clog2(OUT_W + 1);
  localparam int unsigned DRAIN_W   = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam int unsigned VEC_TOTAL = 1 << IN_W;

  state_e               r_state;
  state_e               w_next;
  logic                 w_accept;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic                 r_in_ready;
  logic                 r_busy;
  logic                 r_done;

  logic [CNT_W-1:0]     r_vec_cnt;
  logic [CNT_W-1:0]     r_mismatch_cnt;
  logic [HD_W-1:0]      r_hd_sum;
  logic [ABS_W-1:0]     r_abs_err_sum;
  logic [OUT_W-1:0]     r_max_abs_err;

  logic                 r_s1_valid;
  logic [OUT_W-1:0]     r_s1_diff;
  logic [POP_W-1:0]     r_s1_pop;
  logic [OUT_W-1:0]     r_s1_abs;

  logic [OUT_W-1:0]     w_diff;
  logic [POP_W-1:0]     w_pop;
  logic [OUT_W-1:0]     w_abs;

  err_mon_diff #(
    .OUT_W (OUT_W),
    .POP_W (POP_W)
  ) u_diff (
    .exact_po  (exact_po),
    .approx_po (approx_po),
    .diff_c    (w_diff),
    .pop_c     (w_pop),
    .abs_c     (w_abs)
  );

  // Next-state and acceptance; start from any state restarts a clean run.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        if (start) begin
          w_next = RUN;
        end else begin
          w_accept = in_valid && r_in_ready;
          if (w_accept && (r_vec_cnt == CNT_W'(VEC_TOTAL - 1))) w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (start)                                          w_next = RUN;
        else if (r_drain_cnt == DRAIN_W'(PIPE_DEPTH - 1))   w_next = DONE;
      end
      DONE: begin
        if (start) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == RUN);
      r_busy      <= (w_next == RUN) || (w_next == DRAIN);
      r_done      <= (w_next == DONE);
      if ((r_state == DRAIN) && (w_next == DRAIN)) r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
      else                                         r_drain_cnt <= '0;
    end
  end

  // Stage 1 captures per-pair terms; stage 2 folds them into the accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_cnt      <= '0;
      r_s1_valid     <= 1'b0;
      r_s1_diff      <= '0;
      r_s1_pop       <= '0;
      r_s1_abs       <= '0;
      r_mismatch_cnt <= '0;
      r_hd_sum       <= '0;
      r_abs_err_sum  <= '0;
      r_max_abs_err  <= '0;
    end else if (start) begin
      r_vec_cnt      <= '0;
      r_s1_valid     <= 1'b0;
      r_mismatch_cnt <= '0;
      r_hd_sum       <= '0;
      r_abs_err_sum  <= '0;
      r_max_abs_err  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_vec_cnt <= r_vec_cnt + CNT_W'(1);
        r_s1_diff <= w_diff;
        r_s1_pop  <= w_pop;
        r_s1_abs  <= w_abs;
      end
      if (r_s1_valid) begin
        if (r_s1_diff != '0) r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
        r_hd_sum      <= r_hd_sum + HD_W'(r_s1_pop);
        r_abs_err_sum <= r_abs_err_sum + ABS_W'(r_s1_abs);
        if (r_s1_abs > r_max_abs_err) r_max_abs_err <= r_s1_abs;
      end
    end
  end

`ifdef ERR_MON_WORST_VEC_EN
  logic [IN_W-1:0] r_s1_idx;
  logic [IN_W-1:0] r_worst_vec;

  // Strictly-greater update keeps the earliest vector on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_idx    <= '0;
      r_worst_vec <= '0;
    end else if (start) begin
      r_worst_vec <= '0;
    end else begin
      if (w_accept) r_s1_idx <= r_vec_cnt[IN_W-1:0];
      if (r_s1_valid && (r_s1_abs > r_max_abs_err)) r_worst_vec <= r_s1_idx;
    end
  end

  assign worst_vec = r_worst_vec;
`else
  assign worst_vec = '0;
`endif

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign vec_cnt      = r_vec_cnt;
  assign mismatch_cnt = r_mismatch_cnt;
  assign hd_sum       = r_hd_sum;
  assign abs_err_sum  = r_abs_err_sum;
  assign max_abs_err  = r_max_abs_err;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed, table-driven bench for approx_error_monitor (IN_W=7, OUT_W=4).
module tb_approx_error_monitor;

  localparam int unsigned IN_W  = 7;
  localparam int unsigned OUT_W = 4;
  localparam int          NVEC  = 128;

`ifdef ERR_MON_WORST_VEC_EN
  localparam bit WORST_EN = 1'b1;
`else
  localparam bit WORST_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_W-1:0]     exact_po;
  logic [OUT_W-1:0]     approx_po;
  logic                 busy;
  logic                 done;
  logic [IN_W:0]        vec_cnt;
  logic [IN_W:0]        mismatch_cnt;
  logic [IN_W+2:0]      hd_sum;
  logic [IN_W+OUT_W-1:0] abs_err_sum;
  logic [OUT_W-1:0]     max_abs_err;
  logic [IN_W-1:0]      worst_vec;

  int n_cmp  = 0;
  int n_fail = 0;

  approx_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .exact_po     (exact_po),
    .approx_po    (approx_po),
    .busy         (busy),
    .done         (done),
    .vec_cnt      (vec_cnt),
    .mismatch_cnt (mismatch_cnt),
    .hd_sum       (hd_sum),
    .abs_err_sum  (abs_err_sum),
    .max_abs_err  (max_abs_err),
    .worst_vec    (worst_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pat;
    bit rnd;
    int exp_mis;
    int exp_hd;
    int exp_abs;
    int exp_max;
    int exp_worst;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pattern generator: returns {exact, approx} for vector idx.
  function automatic logic [7:0] gen_pair(input int pat, input int idx);
    logic [3:0] k;
    logic [3:0] e;
    logic [3:0] a;
    k = 4'(idx);
    e = k;
    a = k;
    case (pat)
      1: a = k ^ 4'b0001;
      2: if (idx == 37) begin e = 4'd15; a = 4'd0; end
      4: a = 4'd0;
      5: begin e = 4'd15; a = k; end
      6: a = ~k;
      default: ;
    endcase
    return {e, a};
  endfunction

  // Pulse start, then offer n pairs, tracking acceptances at the bench side.
  task automatic feed(input int pat, input bit rnd, input int n);
    int   idx;
    int   cyc;
    int   trk_err;
    logic rdy;
    bit   v;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("in_ready_after_start", int'(in_ready), 1);
    idx = 0;
    cyc = 0;
    trk_err = 0;
    while (idx < n && cyc < 4000) begin
      rdy = in_ready;
      v   = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      {exact_po, approx_po} = gen_pair(pat, idx);
      in_valid = v;
      @(negedge clk);
      cyc++;
      if (v && rdy) idx++;
      if (int'(vec_cnt) != idx) trk_err++;
    end
    in_valid = 1'b0;
    if (idx < n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL feed_timeout: accepted %0d expected %0d", idx, n);
    end
    check("vec_cnt_track_errors", trk_err, 0);
  endtask

  // Called at the negedge right after the last accepting edge.
  task automatic check_end(input vec_t r);
    in_valid  = 1'b1;
    exact_po  = 4'hF;
    approx_po = 4'h0;
    check("in_ready_low_after_last", int'(in_ready), 0);
    check("busy_in_drain", int'(busy), 1);
    check("done_low_drain0", int'(done), 0);
    @(negedge clk);
    check("done_low_drain1", int'(done), 0);
    @(negedge clk);
    check("done_high", int'(done), 1);
    check("busy_low_done", int'(busy), 0);
    in_valid = 1'b0;
    check("vec_cnt_final", int'(vec_cnt), NVEC);
    check("mismatch_cnt", int'(mismatch_cnt), r.exp_mis);
    check("hd_sum", int'(hd_sum), r.exp_hd);
    check("abs_err_sum", int'(abs_err_sum), r.exp_abs);
    check("max_abs_err", int'(max_abs_err), r.exp_max);
    check("worst_vec", int'(worst_vec), WORST_EN ? r.exp_worst : 0);
    @(negedge clk);
    check("done_held", int'(done), 1);
    check("vec_cnt_held", int'(vec_cnt), NVEC);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_vec_cnt"}, int'(vec_cnt), 0);
    check({tag, "_mismatch"}, int'(mismatch_cnt), 0);
    check({tag, "_hd"}, int'(hd_sum), 0);
    check({tag, "_abs"}, int'(abs_err_sum), 0);
    check({tag, "_max"}, int'(max_abs_err), 0);
    check({tag, "_worst"}, int'(worst_vec), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t clean;
    tbl[0] = '{pat: 0, rnd: 1'b0, exp_mis: 0,   exp_hd: 0,   exp_abs: 0,    exp_max: 0,  exp_worst: 0};
    tbl[1] = '{pat: 1, rnd: 1'b0, exp_mis: 128, exp_hd: 128, exp_abs: 128,  exp_max: 1,  exp_worst: 0};
    tbl[2] = '{pat: 2, rnd: 1'b0, exp_mis: 1,   exp_hd: 4,   exp_abs: 15,   exp_max: 15, exp_worst: 37};
    tbl[3] = '{pat: 3, rnd: 1'b1, exp_mis: 0,   exp_hd: 0,   exp_abs: 0,    exp_max: 0,  exp_worst: 0};
    tbl[4] = '{pat: 4, rnd: 1'b0, exp_mis: 120, exp_hd: 256, exp_abs: 960,  exp_max: 15, exp_worst: 15};
    tbl[5] = '{pat: 5, rnd: 1'b0, exp_mis: 120, exp_hd: 256, exp_abs: 960,  exp_max: 15, exp_worst: 0};
    tbl[6] = '{pat: 6, rnd: 1'b0, exp_mis: 128, exp_hd: 512, exp_abs: 1024, exp_max: 15, exp_worst: 0};
    clean = tbl[0];

    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    exact_po  = '0;
    approx_po = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Valid pairs while idle must be ignored.
    in_valid  = 1'b1;
    exact_po  = 4'hF;
    approx_po = 4'h0;
    repeat (3) @(negedge clk);
    check("idle_vec_cnt", int'(vec_cnt), 0);
    check("idle_in_ready", int'(in_ready), 0);
    check("idle_mismatch", int'(mismatch_cnt), 0);
    in_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      feed(tbl[i].pat, tbl[i].rnd, NVEC);
      check_end(tbl[i]);
    end

    // Restart mid-run after 60 mismatching accepts, then a clean run.
    feed(1, 1'b0, 60);
    feed(0, 1'b0, NVEC);
    check_end(clean);

    // Restart while draining.
    feed(6, 1'b0, NVEC);
    feed(0, 1'b0, NVEC);
    check_end(clean);

    // Asynchronous reset mid-run, away from any clock edge.
    feed(1, 1'b0, 50);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_ready", int'(in_ready), 0);
    check("post_rst_idle_busy", int'(busy), 0);
    feed(0, 1'b0, NVEC);
    check_end(clean);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_error_monitor.md
# approx_error_monitor

- Synthesizable response-side checker for approximate-circuit evaluation.
- Consumes a stream of paired output words: the exact circuit's `po` and the approximate partition's `po`, one pair per exhaustive input vector.
- Accumulates the team's error metrics in hardware: mismatch count, Hamming-distance sum, absolute-error sum and maximum absolute error.
- Raises `done` after all 2**IN_W vectors have been checked. It sits downstream of the stimulus driver and both DUT instances, replacing per-vector printout.

## Interface
- IN_W, 7: partition input width; the run length is 2**IN_W vectors.
- OUT_W, 4: partition output width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears the accumulators and begins a run.
- in_valid  in  1  the current exact_po/approx_po pair is valid.
- in_ready  out  1  the block accepts the pair this cycle.
- exact_po  in  OUT_W  golden output, unsigned.
- approx_po  in  OUT_W  approximate output, unsigned.
- busy  out  1  a run is in progress.
- done  out  1  high once the run completes; held until the next start or reset.
- vec_cnt  out  IN_W+1  number of pairs accepted.
- mismatch_cnt  out  IN_W+1  number of pairs with exact_po != approx_po.
- hd_sum  out  IN_W+$clog2(OUT_W+1)  sum of popcount(exact_po ^ approx_po).
- abs_err_sum  out  IN_W+OUT_W  sum of |exact_po - approx_po|.
- max_abs_err  out  OUT_W  maximum of |exact_po - approx_po|.
- worst_vec  out  IN_W  index of the vector producing max_abs_err (see Configuration).

## Operation
- FSM states:
  - IDLE: in_ready=0.
  - RUN: in_ready=1 while the accepted count is below 2**IN_W.
  - DRAIN: waits for the pipeline to empty.
  - DONE: done=1, busy=0.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DRAIN on the cycle the 2**IN_W-th pair is accepted.
  - DRAIN→DONE after 2 cycles.
  - DONE→RUN on start.
  - start in RUN or DRAIN restarts: accumulators are cleared, in-flight pipeline data is discarded, and the FSM enters RUN.
- Handshake: a pair is accepted when in_valid && in_ready. The input index equals vec_cnt at the moment of acceptance. Gaps in in_valid are allowed indefinitely.
- Stage 1 registers diff = exact_po ^ approx_po, the absolute difference (OUT_W bits, unsigned subtraction of the larger minus the smaller), a valid bit and the vector index.
- Stage 2 updates the accumulators when the stage-1 valid bit is set:
  - mismatch_cnt increments if diff != 0.
  - hd_sum adds popcount(diff).
  - abs_err_sum adds the absolute difference.
  - max_abs_err is updated on a strictly greater value, so ties keep the earliest vector.
- Accumulator widths are sized for the full run; no saturation or wrap can occur within one run.
- in_valid outside RUN is ignored, and no counter changes.

## Timing
- Reset values: busy=0, done=0, in_ready=0, and every counter, accumulator, max and worst_vec = 0. The FSM resets to IDLE.
- in_ready rises the cycle after start.
- A pair accepted at edge N is reflected in the metric outputs after edge N+2. vec_cnt updates at edge N+1.
- done rises 2 cycles after the last acceptance. busy falls in the same cycle.
- Asserting rst_n low mid-run clears everything immediately, regardless of the clock.

## Configuration
- ERR_MON_WORST_VEC_EN defined:
  - a stage-2 register captures the index of the first vector attaining the current max_abs_err;
  - worst_vec drives that register.
- Undefined:
  - the register and its comparator logic are not built;
  - worst_vec is tied to 0.

## Structure
- Shared package err_mon_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - a function computing the accumulator widths from IN_W and OUT_W;
  - localparam PIPE_DEPTH=2.
- One sub-module, err_mon_diff: combinational XOR, popcount and absolute difference for one pair, instantiated in stage 1.

## Test plan
- Identical streams (approx_po=exact_po=index[3:0]), 128 vectors → vec_cnt=128, mismatch_cnt=0, hd_sum=0, abs_err_sum=0, max_abs_err=0, done high 2 cycles after the last accept.
- approx_po = exact_po ^ 4'b0001 for all 128 vectors → mismatch_cnt=128, hd_sum=128, abs_err_sum=128, max_abs_err=1.
- Only vector 37 differs (exact=15, approx=0), identical elsewhere → mismatch_cnt=1, hd_sum=4, abs_err_sum=15, max_abs_err=15, worst_vec=37 with the macro and 0 without it.
- in_valid toggled pseudo-randomly (about 50% duty) with the same stream as the first scenario → identical final metrics; accepted count never exceeds 128; in_ready low after the 128th acceptance.
- start pulsed after 60 accepts with mismatching data, then a clean 128-vector run → final metrics equal the clean-run values from the first scenario.
- rst_n pulled low mid-run → all outputs 0 asynchronously and the FSM in IDLE; a subsequent start runs correctly.
